// File: rtl/pc_sequencer.sv
// Fetch/branch sequencer for an 8-bit program counter: FETCH/DECODE handshake,
// jump/call/return/halt resolution and a small hardware return-address stack.
module pc_sequencer #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Start,
  input  logic                          MemReady,
  input  logic                          Jump,
  input  logic                          Call,
  input  logic                          Ret,
  input  logic                          Halt,
  input  logic [ADDR_W-1:0]             JumpAddr,
  input  logic [ADDR_W-1:0]             PcValue,
  output logic                          FetchReq,
  output logic                          CountEn,
  output logic                          Load,
  output logic [ADDR_W-1:0]             LoadAddr,
  output logic                          Halted,
  output logic                          Error,
  output logic [$clog2(STACK_DEPTH):0]  StackDepth
);

  localparam int PTR_W   = $clog2(STACK_DEPTH);
  localparam int DEPTH_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, FETCH, DECODE, HALT} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
  logic [PTR_W-1:0]  push_idx;
  logic [PTR_W-1:0]  top_idx;
  logic              stack_empty;
  logic              stack_full;
  logic              do_push;

  // StackDepth doubles as the write pointer; the entry below it is the top.
  assign push_idx    = StackDepth[PTR_W-1:0];
  assign top_idx     = push_idx - PTR_W'(1);
  assign stack_empty = (StackDepth == '0);
  assign stack_full  = (StackDepth == DEPTH_W'(STACK_DEPTH));
  assign do_push     = (state_reg == DECODE) && !Halt && !Ret && Call && !stack_full;

  always_ff @(posedge Clk) begin
    if (!Reset && do_push) begin
      stack_mem[push_idx] <= PcValue + ADDR_W'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg  <= IDLE;
      FetchReq   <= 1'b0;
      CountEn    <= 1'b0;
      Load       <= 1'b0;
      LoadAddr   <= '0;
      Halted     <= 1'b0;
      Error      <= 1'b0;
      StackDepth <= '0;
    end else begin
      // PC pulses last exactly one cycle: the first cycle of the next FETCH.
      CountEn <= 1'b0;
      Load    <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Start) begin
            state_reg <= FETCH;
            FetchReq  <= 1'b1;
          end
        end
        FETCH: begin
          if (MemReady) begin
            state_reg <= DECODE;
            FetchReq  <= 1'b0;
          end
        end
        DECODE: begin
          if (Halt) begin
            state_reg <= HALT;
            Halted    <= 1'b1;
          end else if (Ret) begin
            if (stack_empty) begin
              Error     <= 1'b1;
              state_reg <= HALT;
              Halted    <= 1'b1;
            end else begin
              LoadAddr   <= stack_mem[top_idx];
              Load       <= 1'b1;
              StackDepth <= StackDepth - DEPTH_W'(1);
              state_reg  <= FETCH;
              FetchReq   <= 1'b1;
            end
          end else if (Call) begin
            if (stack_full) begin
              Error     <= 1'b1;
              state_reg <= HALT;
              Halted    <= 1'b1;
            end else begin
              LoadAddr   <= JumpAddr;
              Load       <= 1'b1;
              StackDepth <= StackDepth + DEPTH_W'(1);
              state_reg  <= FETCH;
              FetchReq   <= 1'b1;
            end
          end else if (Jump) begin
            LoadAddr  <= JumpAddr;
            Load      <= 1'b1;
            state_reg <= FETCH;
            FetchReq  <= 1'b1;
          end else begin
            CountEn   <= 1'b1;
            state_reg <= FETCH;
            FetchReq  <= 1'b1;
          end
        end
        HALT: begin
          // An error latches the sequencer here until Reset.
          if (Start && !Error) begin
            state_reg <= FETCH;
            Halted    <= 1'b0;
            FetchReq  <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          FetchReq  <= 1'b0;
          Halted    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus random stimulus, checked every
// cycle against a queue-based behavioural model; the bench also plays the PC.
module tb_pc_sequencer;

  localparam int M_IDLE = 0, M_FETCH = 1, M_DECODE = 2, M_HALT = 3;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1, Start = 1'b0, MemReady = 1'b0;
  logic       Jump = 1'b0, Call = 1'b0, Ret = 1'b0, Halt = 1'b0;
  logic [7:0] JumpAddr = 8'h00, pc_val = 8'h00;
  logic       FetchReq, CountEn, Load, Halted, Error;
  logic [7:0] LoadAddr;
  logic [2:0] StackDepth;

  always #5 Clk = ~Clk;

  pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MemReady(MemReady),
    .Jump(Jump), .Call(Call), .Ret(Ret), .Halt(Halt),
    .JumpAddr(JumpAddr), .PcValue(pc_val),
    .FetchReq(FetchReq), .CountEn(CountEn), .Load(Load), .LoadAddr(LoadAddr),
    .Halted(Halted), .Error(Error), .StackDepth(StackDepth)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cnt_seen = 0;
  int load_seen = 0;

  // Behavioural model state
  int         m_state = M_IDLE;
  bit         e_fetch = 0, e_cnt = 0, e_load = 0, e_halted = 0, e_err = 0;
  logic [7:0] e_addr = 8'h00;
  logic [7:0] ret_stack[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [7:0] ret_addr;
    e_cnt  = 0;
    e_load = 0;
    if (Reset) begin
      m_state = M_IDLE;
      e_addr  = 8'h00;
      e_err   = 0;
      ret_stack.delete();
    end else begin
      case (m_state)
        M_IDLE:   if (Start) m_state = M_FETCH;
        M_FETCH:  if (MemReady) m_state = M_DECODE;
        M_DECODE: begin
          if (Halt) m_state = M_HALT;
          else if (Ret) begin
            if (ret_stack.size() == 0) begin
              e_err = 1; m_state = M_HALT;
            end else begin
              e_addr = ret_stack.pop_back(); e_load = 1; m_state = M_FETCH;
            end
          end else if (Call) begin
            if (ret_stack.size() == 4) begin
              e_err = 1; m_state = M_HALT;
            end else begin
              ret_addr = pc_val + 8'd1;
              ret_stack.push_back(ret_addr);
              e_addr = JumpAddr; e_load = 1; m_state = M_FETCH;
            end
          end else if (Jump) begin
            e_addr = JumpAddr; e_load = 1; m_state = M_FETCH;
          end else begin
            e_cnt = 1; m_state = M_FETCH;
          end
        end
        default:  if (Start && !e_err) m_state = M_FETCH;
      endcase
    end
    e_fetch  = (m_state == M_FETCH);
    e_halted = (m_state == M_HALT);
  endtask

  task automatic check_all();
    check_eq("FetchReq", 32'(FetchReq), 32'(e_fetch));
    check_eq("CountEn", 32'(CountEn), 32'(e_cnt));
    check_eq("Load", 32'(Load), 32'(e_load));
    check_eq("LoadAddr", 32'(LoadAddr), 32'(e_addr));
    check_eq("Halted", 32'(Halted), 32'(e_halted));
    check_eq("Error", 32'(Error), 32'(e_err));
    check_eq("StackDepth", 32'(StackDepth), 32'(ret_stack.size()));
  endtask

  // One clock cycle: apply inputs, advance model, check, then let the PC react.
  task automatic cyc(input bit rst, input bit st, input bit mem, input bit j,
                     input bit c, input bit r, input bit h, input logic [7:0] addr);
    bit         prev_load, prev_cnt, was_decode;
    logic [7:0] prev_addr, pc_seen;
    Reset = rst; Start = st; MemReady = mem;
    Jump = j; Call = c; Ret = r; Halt = h; JumpAddr = addr;
    prev_load  = e_load;
    prev_cnt   = e_cnt;
    prev_addr  = e_addr;
    was_decode = (m_state == M_DECODE) && !rst;
    pc_seen    = pc_val;
    @(posedge Clk);
    model_step();
    #1;
    check_all();
    cnt_seen  += int'(CountEn);
    load_seen += int'(Load);
    if (prev_load) pc_val = prev_addr;
    else if (prev_cnt) pc_val = pc_val + 8'd1;
    if (was_decode)
      $display("decode pc=%02h j%0d c%0d r%0d h%0d -> load=%0d cnt=%0d addr=%02h depth=%0d halted=%0d err=%0d",
               pc_seen, j, c, r, h, Load, CountEn, LoadAddr, StackDepth, Halted, Error);
  endtask

  task automatic instr(input bit j, input bit c, input bit r, input bit h,
                       input logic [7:0] addr, input int waits, input int force_pc);
    repeat (waits) cyc(0, 0, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h00);
    if (force_pc >= 0) pc_val = 8'(force_pc);
    cyc(0, 0, 0, j, c, r, h, addr);
  endtask

  initial begin
    int fetch_hi;
    // Reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
    cyc(1, 1, 1, 1, 1, 1, 1, 8'hAA);
    check_eq("reset_depth", 32'(StackDepth), 32'd0);

    // Sequential fetch, MemReady always high
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
    cnt_seen = 0; load_seen = 0;
    repeat (4) instr(0, 0, 0, 0, 8'h00, 0, -1);
    check_eq("seq_counten_pulses", 32'(cnt_seen), 32'd4);
    check_eq("seq_no_load", 32'(load_seen), 32'd0);

    // Wait states: FetchReq high for 4 cycles, then one CountEn
    fetch_hi = 0; cnt_seen = 0;
    if (FetchReq) fetch_hi++;
    repeat (3) begin cyc(0, 0, 0, 0, 0, 0, 0, 8'h00); fetch_hi += int'(FetchReq); end
    cyc(0, 0, 1, 0, 0, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 0, 0, 0, 8'h00);
    check_eq("wait_fetchreq_cycles", 32'(fetch_hi), 32'd4);
    check_eq("wait_one_counten", 32'(cnt_seen), 32'd1);

    // Call from 0x10 to 0x40, then return to 0x11
    instr(0, 1, 0, 0, 8'h40, 0, 8'h10);
    check_eq("call_load", 32'(Load), 32'd1);
    check_eq("call_addr", 32'(LoadAddr), 32'h40);
    check_eq("call_depth", 32'(StackDepth), 32'd1);
    instr(0, 0, 1, 0, 8'h00, 1, -1);
    check_eq("ret_load", 32'(Load), 32'd1);
    check_eq("ret_addr", 32'(LoadAddr), 32'h11);
    check_eq("ret_depth", 32'(StackDepth), 32'd0);

    // Call from 0xFF wraps the return address to 0x00
    instr(0, 1, 0, 0, 8'h20, 0, 8'hFF);
    instr(1, 0, 0, 0, 8'h77, 0, -1);
    instr(0, 0, 1, 0, 8'h00, 0, -1);
    check_eq("wrap_ret_addr", 32'(LoadAddr), 32'h00);

    // Overflow on the fifth nested call
    repeat (4) instr(0, 1, 0, 0, 8'h50, 0, -1);
    check_eq("full_depth", 32'(StackDepth), 32'd4);
    instr(0, 1, 0, 0, 8'h60, 0, -1);
    check_eq("ovf_error", 32'(Error), 32'd1);
    check_eq("ovf_halted", 32'(Halted), 32'd1);
    check_eq("ovf_no_load", 32'(Load), 32'd0);
    repeat (2) cyc(0, 1, 1, 0, 0, 0, 0, 8'h00);
    check_eq("err_start_ignored", 32'(Halted), 32'd1);

    // Underflow after reset
    cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
    instr(0, 0, 1, 0, 8'h00, 0, -1);
    check_eq("udf_error", 32'(Error), 32'd1);
    check_eq("udf_halted", 32'(Halted), 32'd1);

    // Halt beats Jump; resume; reset mid-fetch
    cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
    instr(1, 0, 0, 1, 8'h99, 0, -1);
    check_eq("halt_prio_halted", 32'(Halted), 32'd1);
    check_eq("halt_prio_no_load", 32'(Load), 32'd0);
    cyc(0, 1, 0, 0, 0, 0, 0, 8'h00);
    check_eq("resume_fetch", 32'(FetchReq), 32'd1);
    instr(0, 1, 0, 0, 8'h33, 0, -1);
    repeat (2) cyc(0, 0, 0, 0, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
    check_eq("rst_fetchreq", 32'(FetchReq), 32'd0);
    check_eq("rst_depth", 32'(StackDepth), 32'd0);
    check_eq("rst_no_pulse", 32'(Load | CountEn), 32'd0);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0)
        pc_val = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
          $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 14) == 0, 8'($urandom));
      if (Error && $urandom_range(0, 9) == 0) cyc(1, 0, 0, 0, 0, 0, 0, 8'h00);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch/branch controller that drives the 8-bit program counter's CountEn, Load and A inputs. It sequences FETCH -> DECODE per instruction with a memory-ready handshake, and resolves sequential, jump, call, return and halt operations. It holds a small hardware return-address stack for call/return. It sits between the instruction decoder and the program counter; PcValue is fed back from the counter's Y output.

Parameters:
ADDR_W, 8, address width; must match the program counter width.
STACK_DEPTH, 4, number of return-address stack entries (power of two, at least 2).

Ports:
Clk  input  1  system clock; all state updates on posedge Clk.
Reset  input  1  synchronous, active-high reset.
Start  input  1  level; starts or resumes sequencing from IDLE or HALT.
MemReady  input  1  instruction memory has returned the word for the current PC.
Jump  input  1  decoded op is an unconditional jump; sampled in DECODE only.
Call  input  1  decoded op is a call; sampled in DECODE only.
Ret  input  1  decoded op is a return; sampled in DECODE only.
Halt  input  1  decoded op is a halt; sampled in DECODE only.
JumpAddr  input  ADDR_W  jump/call target.
PcValue  input  ADDR_W  current PC, from the counter's Y output.
FetchReq  output  1  fetch request to instruction memory.
CountEn  output  1  one-cycle increment pulse to the PC.
Load  output  1  one-cycle load pulse to the PC.
LoadAddr  output  ADDR_W  value to load; drives the PC's A input.
Halted  output  1  high while in HALT.
Error  output  1  sticky stack overflow/underflow flag.
StackDepth  output  clog2(STACK_DEPTH)+1  current number of valid stack entries.

Behaviour:
- All outputs are registered.
- Reset (Reset=1 at posedge) takes priority over everything:
  - state <= IDLE; FetchReq, CountEn, Load, Halted, Error <= 0; LoadAddr <= 0; StackDepth <= 0.
  - Stack contents are don't-care after reset.
  - Reset in any state, including mid-fetch, aborts the operation. No Load or CountEn pulse is emitted for the aborted instruction.
- States: IDLE, FETCH, DECODE, HALT.
- IDLE:
  - All outputs low.
  - Start=1 -> FETCH.
- FETCH:
  - FetchReq=1 for every cycle in FETCH.
  - MemReady=0 -> stay in FETCH (wait states are unbounded).
  - MemReady=1 -> DECODE next cycle; FetchReq drops with the transition.
- DECODE lasts exactly one cycle. Op priority: Halt > Ret > Call > Jump > sequential.
  - Halt: no PC pulse; -> HALT.
  - Ret with StackDepth=0: Error<=1; no PC pulse; -> HALT.
  - Ret otherwise: pop top entry; LoadAddr<=popped; Load pulse; StackDepth-1; -> FETCH.
  - Call with StackDepth=STACK_DEPTH: Error<=1; no push; no PC pulse; -> HALT.
  - Call otherwise: push (PcValue+1) mod 2^ADDR_W, so 8'hFF pushes 8'h00; LoadAddr<=JumpAddr; Load pulse; StackDepth+1; -> FETCH.
  - Jump: LoadAddr<=JumpAddr; Load pulse; stack unchanged; -> FETCH.
  - None asserted: CountEn pulse; -> FETCH. PC wrap from 8'hFF to 8'h00 is the counter's natural behaviour and is not flagged.
- Pulse timing:
  - The Load/CountEn pulse is high for exactly the one cycle following DECODE, which is the first cycle of the next FETCH.
  - Load and CountEn are never high together.
  - LoadAddr is stable for the whole Load cycle and holds its value afterwards.
  - The PC updates within that cycle, so PcValue is valid by the following DECODE.
  - Minimum instruction period is 2 cycles (MemReady=1 immediately).
- HALT:
  - Halted=1; FetchReq=0.
  - Start=1 and Error=0 -> FETCH (resumes at the current PcValue); Halted drops.
  - Start is ignored while Error=1; only Reset clears Error.
- Op inputs outside DECODE are ignored. MemReady outside FETCH is ignored.

Test Plan:
- Sequential fetch: Reset, then Start=1, MemReady=1 always, no ops -> FetchReq/CountEn alternate; 4 CountEn pulses in 8 cycles after entering FETCH; Load never high.
- Wait states: MemReady held low 3 cycles in FETCH -> FetchReq high 4 cycles; exactly one CountEn afterwards.
- Jump/call/return: PcValue=8'h10, Call with JumpAddr=8'h40 -> Load, LoadAddr=8'h40, StackDepth=1. Then Ret -> Load, LoadAddr=8'h11, StackDepth=0.
- Call wrap: PcValue=8'hFF, Call to 8'h20 -> later Ret loads 8'h00.
- Stack errors: 5 nested Calls with STACK_DEPTH=4 -> 5th gives Error=1, Halted=1, no Load. After Reset, a Ret at depth 0 -> Error=1, HALT. Start with Error=1 stays in HALT.
- Priority and reset: Halt+Jump together in DECODE -> HALT, no Load. Start resumes FETCH. Reset asserted during FETCH wait -> IDLE next cycle, all outputs 0, StackDepth=0.
